// File: rtl/led_scroll_scheduler.sv
// Four-digit 7-segment scan sequencer with a 16-entry message buffer.
// Blanks between digits and scrolls a 4-character window.
module led_scroll_scheduler #(
  parameter int DIGIT_TICKS   = 16,
  parameter int BLANK_TICKS   = 2,
  parameter int SCROLL_FRAMES = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [3:0] wr_addr,
  input  logic [3:0] wr_data,
  output logic       wr_ready,
  input  logic       scroll_en,
  output logic [3:0] char,
  output logic       an3,
  output logic       an2,
  output logic       an1,
  output logic       an0,
  output logic       frame_tick,
  output logic [3:0] offset
);

  localparam int SW = (DIGIT_TICKS > 1) ? $clog2(DIGIT_TICKS) : 1;
  localparam int FW = (SCROLL_FRAMES > 1) ? $clog2(SCROLL_FRAMES) : 1;

  localparam logic [SW-1:0] BLAST = SW'(BLANK_TICKS - 1);
  localparam logic [SW-1:0] DLAST = SW'(DIGIT_TICKS - BLANK_TICKS - 1);
  localparam logic [FW-1:0] FLAST = FW'(SCROLL_FRAMES - 1);

  typedef enum logic {
    S_BLANK,
    S_DRIVE
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [SW-1:0]   r_cnt;
  logic [SW-1:0]   w_cnt_nxt;
  logic [1:0]      r_d;
  logic [1:0]      w_d_nxt;

  logic [3:0]      r_an;
  logic [3:0]      w_an_nxt;
  logic            r_ft;
  logic            w_ft_nxt;
  logic            r_rdy;
  logic            w_rdy_nxt;
  logic [3:0]      r_char;
  logic [3:0]      r_offset;
  logic [FW-1:0]   r_fcnt;
  logic [3:0]      r_buf [16];

  logic            w_blank_last;
  logic            w_drive_last;
  logic            w_wr;
  logic [3:0]      w_idx;

  assign w_blank_last = (r_state == S_BLANK) && (r_cnt == BLAST);
  assign w_drive_last = (r_state == S_DRIVE) && (r_cnt == DLAST);
  assign w_wr         = wr_en && r_rdy;
  assign w_idx        = r_offset + 4'd3 - {2'b00, r_d};

  assign wr_ready   = r_rdy;
  assign char       = r_char;
  assign an3        = r_an[3];
  assign an2        = r_an[2];
  assign an1        = r_an[1];
  assign an0        = r_an[0];
  assign frame_tick = r_ft;
  assign offset     = r_offset;

  // Next scan state and the registered outputs that follow from it
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + SW'(1);
    w_d_nxt     = r_d;
    if (w_blank_last) begin
      w_state_nxt = S_DRIVE;
      w_cnt_nxt   = '0;
    end else if (w_drive_last) begin
      w_state_nxt = S_BLANK;
      w_cnt_nxt   = '0;
      w_d_nxt     = r_d - 2'd1;
    end
    w_an_nxt  = 4'hF;
    if (w_state_nxt == S_DRIVE)
      w_an_nxt = ~(4'b0001 << w_d_nxt);
    w_rdy_nxt = (w_state_nxt == S_BLANK);
    w_ft_nxt  = (w_state_nxt == S_DRIVE) &&
                (w_cnt_nxt == DLAST) &&
                (w_d_nxt == 2'd0);
  end

  // Scan state register and registered anode/handshake/tick outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_BLANK;
      r_cnt   <= '0;
      r_d     <= 2'd3;
      r_an    <= 4'hF;
      r_ft    <= 1'b0;
      r_rdy   <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_d     <= w_d_nxt;
      r_an    <= w_an_nxt;
      r_ft    <= w_ft_nxt;
      r_rdy   <= w_rdy_nxt;
    end
  end

  // Message buffer; writes only land while the display is blanked
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 16; i++)
        r_buf[i] <= '0;
    end else if (w_wr) begin
      r_buf[wr_addr] <= wr_data;
    end
  end

  // Character latch at the end of blanking, with write bypass
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_char <= '0;
    end else if (w_blank_last) begin
      if (w_wr && (wr_addr == w_idx))
        r_char <= wr_data;
      else
        r_char <= r_buf[w_idx];
    end
  end

  // Frame counting and window advance at frame boundaries only
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fcnt   <= '0;
      r_offset <= '0;
    end else if (!scroll_en) begin
      r_fcnt   <= '0;
    end else if (r_ft) begin
      if (r_fcnt == FLAST) begin
        r_fcnt   <= '0;
        r_offset <= r_offset + 4'd1;
      end else begin
        r_fcnt   <= r_fcnt + FW'(1);
      end
    end
  end

endmodule

// File: tb/tb_led_scroll_scheduler.sv
// Directed bench for the LED scan/scroll scheduler.
// Small timing parameters keep frames at 32 cycles.
module tb_led_scroll_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_en;
  logic [3:0] wr_addr;
  logic [3:0] wr_data;
  logic       wr_ready;
  logic       scroll_en;
  logic [3:0] char;
  logic       an3, an2, an1, an0;
  logic       frame_tick;
  logic [3:0] offset;

  int checks = 0;
  int errors = 0;

  wire [3:0] w_an = {an3, an2, an1, an0};

  always #5 clk = ~clk;

  led_scroll_scheduler #(
    .DIGIT_TICKS(8),
    .BLANK_TICKS(2),
    .SCROLL_FRAMES(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .wr_ready(wr_ready),
    .scroll_en(scroll_en),
    .char(char),
    .an3(an3),
    .an2(an2),
    .an1(an1),
    .an0(an0),
    .frame_tick(frame_tick),
    .offset(offset)
  );

  task automatic wait_ft();
    bit got;
    got = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (frame_tick) begin
        got = 1;
        break;
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL wait_ft timeout frame_tick=%0b required 1", frame_tick);
    end
  endtask

  // Observe one full frame following the current frame_tick cycle
  task automatic capture(output logic [15:0] chars,
                         output logic [3:0] off,
                         output bit stable,
                         output bit tick_ok);
    chars   = 16'hxxxx;
    off     = 4'hx;
    stable  = 1;
    tick_ok = 1;
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      if (k == 0) off = offset;
      else if (offset !== off) stable = 0;
      if (frame_tick !== (k == 31)) tick_ok = 0;
      case (w_an)
        4'b0111: chars[15:12] = char;
        4'b1011: chars[11:8]  = char;
        4'b1101: chars[7:4]   = char;
        4'b1110: chars[3:0]   = char;
        default: ;
      endcase
    end
  endtask

  task automatic test_reset();
    logic [3:0] e_an;
    int slot, pos;
    reset     = 1'b0;
    wr_en     = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;
    scroll_en = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (w_an !== 4'hF || char !== 4'h0 || offset !== 4'h0 ||
        frame_tick !== 1'b0 || wr_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_state an=%b char=%h off=%h ft=%b rdy=%b required 1111 0 0 0 1",
               w_an, char, offset, frame_tick, wr_ready);
    end
    reset = 1'b1;
    for (int k = 0; k < 40; k++) begin
      if (k > 0) @(negedge clk);
      slot = (k / 8) % 4;
      pos  = k % 8;
      e_an = (pos < 2) ? 4'hF : ~(4'b0001 << (3 - slot));
      checks++;
      if (w_an !== e_an) begin
        errors++;
        $display("FAIL reset_seq_an cycle %0d got %b required %b", k, w_an, e_an);
      end
      checks++;
      if (frame_tick !== (k % 32 == 31)) begin
        errors++;
        $display("FAIL reset_seq_tick cycle %0d got %b required %b",
                 k, frame_tick, (k % 32 == 31));
      end
      if (pos >= 2) begin
        checks++;
        if (char !== 4'h0) begin
          errors++;
          $display("FAIL reset_seq_char cycle %0d got %h required 0", k, char);
        end
      end
    end
  endtask

  task automatic test_write();
    bit acc;
    bit seen;
    logic [15:0] ch;
    logic [3:0] off;
    bit st, tk;
    for (int i = 0; i < 16; i++) begin
      wr_en   = 1'b1;
      wr_addr = 4'(i);
      wr_data = 4'(i);
      acc     = 0;
      for (int t = 0; t < 20; t++) begin
        if (wr_ready) begin
          acc = 1;
          checks++;
          if (w_an !== 4'hF) begin
            errors++;
            $display("FAIL write_in_blank addr %0d an=%b required 1111", i, w_an);
          end
          @(negedge clk);
          break;
        end
        @(negedge clk);
      end
      wr_en = 1'b0;
      if (!acc) begin
        checks++;
        errors++;
        $display("FAIL write_timeout addr %0d wr_ready=%b required 1", i, wr_ready);
      end
    end
    seen = 0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (!wr_ready) begin
        seen = 1;
        break;
      end
    end
    checks++;
    if (!seen || w_an === 4'hF) begin
      errors++;
      $display("FAIL drive_wait rdy=%b an=%b required 0 and a driven anode", wr_ready, w_an);
    end
    wr_en   = 1'b1;
    wr_addr = 4'h0;
    wr_data = 4'hF;
    @(negedge clk);
    wr_en = 1'b0;
    wait_ft();
    capture(ch, off, st, tk);
    checks++;
    if (ch !== 16'h0123 || off !== 4'h0) begin
      errors++;
      $display("FAIL write_contents got %h off %h required 0123 off 0", ch, off);
    end
  endtask

  task automatic test_scroll();
    logic [15:0] ch;
    logic [3:0] off;
    bit st, tk;
    @(negedge clk);
    scroll_en = 1'b1;
    wait_ft();
    wait_ft();
    capture(ch, off, st, tk);
    checks++;
    if (off !== 4'h1 || ch !== 16'h1234) begin
      errors++;
      $display("FAIL scroll_first off %h chars %h required 1 1234", off, ch);
    end
    checks++;
    if (!st || !tk) begin
      errors++;
      $display("FAIL scroll_frame_integrity stable=%0b tick=%0b required 1 1", st, tk);
    end
    repeat (25) wait_ft();
    capture(ch, off, st, tk);
    checks++;
    if (off !== 4'hE || ch !== 16'hEF01 || !st) begin
      errors++;
      $display("FAIL scroll_wrap14 off %h chars %h required E EF01", off, ch);
    end
    wait_ft();
    capture(ch, off, st, tk);
    checks++;
    if (off !== 4'hF || ch !== 16'hF012 || !st) begin
      errors++;
      $display("FAIL scroll_wrap15 off %h chars %h required F F012", off, ch);
    end
    wait_ft();
    @(negedge clk);
    checks++;
    if (offset !== 4'h0) begin
      errors++;
      $display("FAIL scroll_wrap0 off %h required 0", offset);
    end
  endtask

  task automatic test_hold();
    repeat (11) wait_ft();
    repeat (10) @(negedge clk);
    checks++;
    if (offset !== 4'h5) begin
      errors++;
      $display("FAIL hold_start off %h required 5", offset);
    end
    scroll_en = 1'b0;
    for (int f = 0; f < 10; f++) begin
      wait_ft();
      @(negedge clk);
      checks++;
      if (offset !== 4'h5) begin
        errors++;
        $display("FAIL hold_frozen frame %0d off %h required 5", f, offset);
      end
    end
    repeat (10) @(negedge clk);
    scroll_en = 1'b1;
    wait_ft();
    @(negedge clk);
    checks++;
    if (offset !== 4'h5) begin
      errors++;
      $display("FAIL hold_resume1 off %h required 5", offset);
    end
    wait_ft();
    @(negedge clk);
    checks++;
    if (offset !== 4'h6) begin
      errors++;
      $display("FAIL hold_resume2 off %h required 6", offset);
    end
    scroll_en = 1'b0;
  endtask

  task automatic test_bypass();
    bit ok;
    ok = 0;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (an2 === 1'b0) begin
        ok = 1;
        break;
      end
    end
    if (ok) begin
      ok = 0;
      for (int t = 0; t < 10; t++) begin
        @(negedge clk);
        if (an2 === 1'b1) begin
          ok = 1;
          break;
        end
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL bypass_sync an=%b required an2 slot end", w_an);
    end
    @(negedge clk);
    checks++;
    if (wr_ready !== 1'b1 || w_an !== 4'hF) begin
      errors++;
      $display("FAIL bypass_blank rdy=%b an=%b required 1 1111", wr_ready, w_an);
    end
    wr_en   = 1'b1;
    wr_addr = 4'h8;
    wr_data = 4'h9;
    @(negedge clk);
    wr_en = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) @(negedge clk);
      checks++;
      if (w_an !== 4'b1101 || char !== 4'h9) begin
        errors++;
        $display("FAIL bypass_char cycle %0d an=%b char=%h required 1101 9", k, w_an, char);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] e_an;
    bit ok;
    ok = 0;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (an2 === 1'b0) begin
        ok = 1;
        break;
      end
    end
    checks++;
    if (!ok || offset !== 4'h6) begin
      errors++;
      $display("FAIL rstmid_setup an=%b off=%h required an2 low off 6", w_an, offset);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (w_an !== 4'hF || offset !== 4'h0 || char !== 4'h0 ||
        wr_ready !== 1'b1 || frame_tick !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_async an=%b off=%h char=%h rdy=%b ft=%b required 1111 0 0 1 0",
               w_an, offset, char, wr_ready, frame_tick);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 16; k++) begin
      if (k > 0) @(negedge clk);
      e_an = ((k % 8) < 2) ? 4'hF : ((k < 8) ? 4'b0111 : 4'b1011);
      checks++;
      if (w_an !== e_an) begin
        errors++;
        $display("FAIL rstmid_seq cycle %0d an=%b required %b", k, w_an, e_an);
      end
      if ((k % 8) >= 2) begin
        checks++;
        if (char !== 4'h0) begin
          errors++;
          $display("FAIL rstmid_char cycle %0d got %h required 0", k, char);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_scroll();
    test_hold();
    test_bypass();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
